// File: rtl/if_id_buffer_if.sv
// Valid/ready stage bus carrying one fetched bundle {pc, ins, cycle, halt}.
// The producer uses the master modport and the consumer uses the slave modport.
`timescale 1ns/1ps

interface if_id_buffer_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] cycle;
    logic        halt;

    modport master (
        output valid,
        output pc,
        output ins,
        output cycle,
        output halt,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  ins,
        input  cycle,
        input  halt,
        output ready
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID buffer with flush squash, halt latching and
// debug counters for retired bundles and decode bubbles.
`timescale 1ns/1ps

module if_id_buffer #(
    parameter logic [31:0] NOP_INS = 32'h00000000,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             clr,
    if_id_buffer_if.slave    fetch,
    if_id_buffer_if.master   decode,
    input  logic             flush,
    output logic             halt_done,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] bubble_count
);

    logic [31:0] pc_mem    [2];
    logic [31:0] ins_mem   [2];
    logic [31:0] cycle_mem [2];
    logic [1:0]  halt_mem;

    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        halt_seen;
    logic        halt_done_q;

    logic        rd_ptr_d;
    logic        wr_ptr_d;
    logic [1:0]  count_d;
    logic        halt_seen_d;
    logic        halt_done_d;

    logic        in_ready;
    logic        out_valid;
    logic        push;
    logic        pop;
    logic        write_en;
    logic        bubble;

    // in_ready looks only at registered state so fetch never sees a
    // combinational path from decode back-pressure or the EX flush.
    assign in_ready  = (count != 2'd2) && !halt_seen && !halt_done_q;
    assign out_valid = (count != 2'd0);
    assign push      = fetch.valid && in_ready;
    assign pop       = out_valid && decode.ready;
    assign write_en  = push && !flush;
    assign bubble    = decode.ready && !out_valid && !halt_done_q;

    always_comb begin
        rd_ptr_d    = rd_ptr;
        wr_ptr_d    = wr_ptr;
        count_d     = count;
        halt_seen_d = halt_seen;
        halt_done_d = halt_done_q;

        if (pop) begin
            rd_ptr_d = ~rd_ptr;
            if (halt_mem[rd_ptr]) begin
                halt_done_d = 1'b1;
            end
        end

        // A flush still lets the same-cycle pop retire, but squashes
        // everything else, including a halt that has not been delivered.
        if (flush) begin
            rd_ptr_d    = 1'b0;
            wr_ptr_d    = 1'b0;
            count_d     = 2'd0;
            halt_seen_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr;
                if (fetch.halt) begin
                    halt_seen_d = 1'b1;
                end
            end
            count_d = count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            halt_seen   <= 1'b0;
            halt_done_q <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr_d;
            wr_ptr      <= wr_ptr_d;
            count       <= count_d;
            halt_seen   <= halt_seen_d;
            halt_done_q <= halt_done_d;
        end
    end

    // Entries are not cleared on pop; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                pc_mem[i]    <= 32'h0;
                ins_mem[i]   <= NOP_INS;
                cycle_mem[i] <= 32'h0;
            end
            halt_mem <= 2'b00;
        end else if (write_en) begin
            pc_mem[wr_ptr]    <= fetch.pc;
            ins_mem[wr_ptr]   <= fetch.ins;
            cycle_mem[wr_ptr] <= fetch.cycle;
            halt_mem[wr_ptr]  <= fetch.halt;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            retired_count <= '0;
            bubble_count  <= '0;
        end else begin
            if (pop) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if (bubble) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

    assign fetch.ready  = in_ready;
    assign decode.valid = out_valid;
    assign decode.pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign decode.ins   = out_valid ? ins_mem[rd_ptr]   : NOP_INS;
    assign decode.cycle = out_valid ? cycle_mem[rd_ptr] : 32'h0;
    assign decode.halt  = out_valid && halt_mem[rd_ptr];
    assign halt_done    = halt_done_q;

    a_count_range : assert property (@(posedge clk) disable iff (clr)
        count != 2'd3);

    a_no_push_when_full : assert property (@(posedge clk) disable iff (clr)
        (count == 2'd2) |-> !in_ready);

endmodule
